// File: rtl/tone_gen_pkg.sv
// Shared definitions for the test-tone source.
// Holds the sample-rate constant, DAC sample width and limits, waveform
// select encodings, the controller state encoding and saturating helpers.
package tone_gen_pkg;
  localparam int FREQ_CONST = 100000;   // sample clocks per second
  localparam int SAMPLE_W   = 12;
  localparam logic [SAMPLE_W-1:0] DAC_MAX = 12'd4095;
  localparam logic [SAMPLE_W-1:0] DAC_MIN = 12'd0;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'b00,
    WAVE_PULSE  = 2'b01,
    WAVE_DC     = 2'b10,
    WAVE_OFF    = 2'b11
  } wave_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // mean + amp, computed one bit wider and clamped to full scale
  function automatic logic [SAMPLE_W-1:0] sat_add(input logic [SAMPLE_W-1:0] a,
                                                   input logic [SAMPLE_W-1:0] b);
    logic [SAMPLE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SAMPLE_W] ? DAC_MAX : s[SAMPLE_W-1:0];
  endfunction

  // mean - amp, clamped to zero on borrow
  function automatic logic [SAMPLE_W-1:0] sat_sub(input logic [SAMPLE_W-1:0] a,
                                                   input logic [SAMPLE_W-1:0] b);
    logic [SAMPLE_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[SAMPLE_W] ? DAC_MIN : d[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/udiv_seq.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Ports: clk, rst (sync, active high, aborts a division), start (loads
// operands), dividend, divisor, done (1-cycle pulse after DIV_W
// iterations), quotient (valid when done pulses, truncated).
// Divisor must be non-zero.
module udiv_seq #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);
  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] rem, quo, dvs;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic [DIV_W:0]   trial, diff;

  // Shift next dividend bit into the partial remainder; the MSB of the
  // difference is the borrow, i.e. trial < divisor.
  always_comb begin
    trial = {rem, quo[DIV_W-1]};
    diff  = trial - {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem <= '0;
        quo <= dividend;
        dvs <= divisor;
        cnt <= CNT_W'(DIV_W);
        run <= 1'b1;
      end else if (run) begin
        if (!diff[DIV_W]) begin
          rem <= diff[DIV_W-1:0];
          quo <= {quo[DIV_W-2:0], 1'b1};
        end else begin
          rem <= trial[DIV_W-1:0];
          quo <= {quo[DIV_W-2:0], 1'b0};
        end
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo;
endmodule

// File: rtl/tone_gen.sv
// Test-tone source: square / 25% pulse / DC / off around a programmable mean.
// Period in clocks = FREQ_CONST / freq_in, computed by a sequential divider.
// Ports: clk, rst (sync, active high), load (latch settings + start divide),
// freq_in, mean, amp, wave_sel; data (registered sample), busy (divide in
// progress), err (last load rejected), period_out (active period).
module tone_gen #(
  parameter int FREQ_CONST = tone_gen_pkg::FREQ_CONST,
  parameter int DIV_W      = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [DIV_W-1:0]                  freq_in,
  input  logic [tone_gen_pkg::SAMPLE_W-1:0] mean,
  input  logic [tone_gen_pkg::SAMPLE_W-1:0] amp,
  input  logic [1:0]                        wave_sel,
  output logic [tone_gen_pkg::SAMPLE_W-1:0] data,
  output logic                              busy,
  output logic                              err,
  output logic [DIV_W-1:0]                  period_out
);
  import tone_gen_pkg::SAMPLE_W;
  import tone_gen_pkg::wave_t;
  import tone_gen_pkg::WAVE_SQUARE;
  import tone_gen_pkg::WAVE_PULSE;
  import tone_gen_pkg::WAVE_DC;
  import tone_gen_pkg::WAVE_OFF;
  import tone_gen_pkg::state_t;
  import tone_gen_pkg::ST_IDLE;
  import tone_gen_pkg::ST_DIV;
  import tone_gen_pkg::ST_RUN;
  import tone_gen_pkg::sat_add;
  import tone_gen_pkg::sat_sub;

  localparam logic [DIV_W-1:0] FREQ_MAX = DIV_W'(FREQ_CONST / 2);

  state_t              state, state_n;
  logic [SAMPLE_W-1:0] data_n, mean_q, mean_n, amp_q, amp_n, sample;
  logic                busy_n, err_n, start_q, start_n;
  logic [DIV_W-1:0]    period_n, phase, phase_n, hi_len, hi_n, freq_q, freq_n;
  wave_t               sel_q, sel_n;
  logic                div_done;
  logic [DIV_W-1:0]    quot;

  udiv_seq #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start_q),
    .dividend (DIV_W'(FREQ_CONST)),
    .divisor  (freq_q),
    .done     (div_done),
    .quotient (quot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      data       <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      period_out <= '0;
      phase      <= '0;
      hi_len     <= '0;
      freq_q     <= '0;
      mean_q     <= '0;
      amp_q      <= '0;
      sel_q      <= WAVE_SQUARE;
      start_q    <= 1'b0;
    end else begin
      state      <= state_n;
      data       <= data_n;
      busy       <= busy_n;
      err        <= err_n;
      period_out <= period_n;
      phase      <= phase_n;
      hi_len     <= hi_n;
      freq_q     <= freq_n;
      mean_q     <= mean_n;
      amp_q      <= amp_n;
      sel_q      <= sel_n;
      start_q    <= start_n;
    end
  end

  // Sample for the current phase; lands on data one cycle later.
  always_comb begin
    sample = '0;
    case (sel_q)
      WAVE_SQUARE,
      WAVE_PULSE: sample = (phase < hi_len) ? sat_add(mean_q, amp_q)
                                            : sat_sub(mean_q, amp_q);
      WAVE_DC:    sample = mean_q;
      WAVE_OFF:   sample = '0;
      default:    sample = '0;
    endcase
  end

  always_comb begin
    state_n  = state;
    data_n   = data;
    busy_n   = busy;
    err_n    = err;
    period_n = period_out;
    phase_n  = phase;
    hi_n     = hi_len;
    freq_n   = freq_q;
    mean_n   = mean_q;
    amp_n    = amp_q;
    sel_n    = sel_q;
    start_n  = 1'b0;
    case (state)
      ST_IDLE, ST_RUN: begin
        if (state == ST_RUN) begin
          data_n  = sample;
          phase_n = (phase == period_out - 1'b1) ? '0 : phase + 1'b1;
        end
        if (load) begin
          freq_n = freq_in;
          mean_n = mean;
          amp_n  = amp;
          sel_n  = wave_t'(wave_sel);
          data_n = mean;
          if (freq_in == '0 || freq_in > FREQ_MAX) begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end else begin
            err_n   = 1'b0;
            start_n = 1'b1;
            state_n = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        // load is deliberately ignored here: settings stay frozen.
        data_n = mean_q;
        if (start_q) busy_n = 1'b1;
        if (div_done) begin
          period_n = quot;
          hi_n     = (sel_q == WAVE_PULSE) ? (quot >> 2) : (quot >> 1);
          phase_n  = '0;
          busy_n   = 1'b0;
          state_n  = ST_RUN;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen: vector table, control corner cases,
// randomized configurations against an arithmetic waveform model, and a
// zero-crossing frequency readback of the generated tone.
module tb_tone_gen;
  localparam int FC = 100000;

  logic        clk = 1'b0;
  logic        rst, load;
  logic [31:0] freq_in;
  logic [11:0] mean, amp;
  logic [1:0]  wave_sel;
  logic [11:0] data;
  logic        busy, err;
  logic [31:0] period_out;

  int errors = 0;
  int checks = 0;
  int last_period = 0;

  tone_gen #(.FREQ_CONST(FC), .DIV_W(32)) dut (
    .clk(clk), .rst(rst), .load(load), .freq_in(freq_in), .mean(mean),
    .amp(amp), .wave_sel(wave_sel), .data(data), .busy(busy), .err(err),
    .period_out(period_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int freq;
    int mean;
    int amp;
    int sel;
    bit bad;
    int period;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected sample k cycles into RUN, straight from the waveform rules.
  function automatic int model(int m, int a, int sel, int period, int k);
    int ph, hi, lo, hl;
    ph = k % period;
    hi = (m + a > 4095) ? 4095 : m + a;
    lo = (m < a) ? 0 : m - a;
    case (sel)
      0: begin hl = period / 2; return (ph < hl) ? hi : lo; end
      1: begin hl = period / 4; return (ph < hl) ? hi : lo; end
      2: return m;
      default: return 0;
    endcase
  endfunction

  task automatic pulse_load(int f, int m, int a, int s);
    @(negedge clk);
    freq_in = f; mean = m; amp = a; wave_sel = s; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Valid load: busy window, data during divide, period, then ncyc samples.
  // intr > 0 issues a conflicting load during the divide at that cycle.
  task automatic check_run(int f, int m, int a, int s, int exp_period, int ncyc, int intr);
    pulse_load(f, m, a, s);
    chk("busy_at_load", busy, 0);
    chk("err_valid", err, 0);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", c), busy, (c <= 33) ? 1 : 0);
      chk("data_div", data, m);
      if (c == intr) begin
        freq_in = 2000; mean = (m + 7) % 4096; amp = 3; wave_sel = 2'b10; load = 1'b1;
      end
      if (intr > 0 && c == intr + 1) load = 1'b0;
    end
    chk($sformatf("period_f%0d", f), period_out, exp_period);
    last_period = exp_period;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      chk($sformatf("sample_f%0d_k%0d", f, k), data, model(m, a, s, FC / f, k));
    end
  endtask

  task automatic err_run(int f, int m, int a, int s);
    pulse_load(f, m, a, s);
    chk($sformatf("err_f%0d", f), err, 1);
    chk("err_data", data, m);
    chk("err_busy", busy, 0);
    chk("err_period_kept", period_out, last_period);
    repeat (3) @(negedge clk);
    chk("err_no_div", busy, 0);
    chk("err_data_hold", data, m);
  endtask

  initial begin
    int f, m, a, s, p, n, cnt, first, last, meas;
    bit prev, cur;
    rst = 1'b1; load = 1'b0; freq_in = '0; mean = '0; amp = '0; wave_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_period", period_out, 0);
    rst = 1'b0;

    vecs.push_back('{1000, 2048, 1000, 0, 1'b0, 100});
    vecs.push_back('{2000, 4000, 500, 0, 1'b0, 50});
    vecs.push_back('{1000, 100, 300, 1, 1'b0, 100});
    vecs.push_back('{0, 1234, 5, 0, 1'b1, 0});
    vecs.push_back('{60000, 777, 5, 0, 1'b1, 0});
    vecs.push_back('{50001, 321, 9, 1, 1'b1, 0});
    vecs.push_back('{50000, 10, 20, 0, 1'b0, 2});
    vecs.push_back('{500, 3000, 100, 2, 1'b0, 200});
    vecs.push_back('{777, 3000, 100, 3, 1'b0, 128});
    vecs.push_back('{7, 1500, 1500, 1, 1'b0, 14285});
    foreach (vecs[i]) begin
      if (vecs[i].bad)
        err_run(vecs[i].freq, vecs[i].mean, vecs[i].amp, vecs[i].sel);
      else begin
        n = (2 * vecs[i].period < 250) ? 2 * vecs[i].period : 250;
        check_run(vecs[i].freq, vecs[i].mean, vecs[i].amp, vecs[i].sel,
                  vecs[i].period, n, 0);
      end
    end

    // load during the divide is ignored; original settings complete
    check_run(1000, 2048, 1000, 0, 100, 120, 5);

    // reset mid-divide
    pulse_load(1000, 2048, 1000, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_data", data, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_err", err, 0);
    chk("rst_mid_period", period_out, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_mid_stays_idle", busy, 0);
    chk("rst_mid_period_after", period_out, 0);
    last_period = 0;

    // randomized configurations
    for (int r = 0; r < 6; r++) begin
      f = $urandom_range(200, 50000);
      m = $urandom_range(0, 4095);
      a = $urandom_range(0, 4095);
      s = $urandom_range(0, 3);
      p = FC / f;
      n = (2 * p < 300) ? 2 * p : 300;
      check_run(f, m, a, s, p, n, 0);
    end

    // loopback readback: cycles between rising crossings of the mean
    check_run(500, 2048, 1000, 0, 200, 0, 0);
    cnt = 0; first = -1; last = -1; prev = 1'b1;
    for (int c = 0; c < 1000 && last < 0; c++) begin
      @(negedge clk);
      cur = (data >= 12'd2048);
      if (cur && !prev) begin
        if (first < 0) first = c; else last = c;
      end
      prev = cur;
    end
    checks++;
    if (last < 0) begin
      errors++;
      $display("FAIL loopback_freq: no two rising crossings within 1000 cycles, required 500");
    end else begin
      meas = FC / (last - first);
      if (meas < 499 || meas > 501) begin
        errors++;
        $display("FAIL loopback_freq: got %0d expected 500 +/-1", meas);
      end
    end

    // odd period: 16666 high then 16667 low
    check_run(3, 2048, 1000, 0, 33333, 33333, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
